v2k_typedef_yee_pixel_rx: RTL and testbench
===========================================

# v2k_typedef_yee_pixel_rx

Receive-side endpoint for the 24-bit pixel stream produced by the sub1 pixel stage. It accepts `pixel24_t` words under a valid/ready handshake and buffers them in a small FIFO. It re-emits them toward the consumer with end-of-line marking. Per line, it reports the wrapping sum of all colour channels. It sits between the pixel pipeline output and any downstream line-oriented consumer.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `LINE_LEN`, 8: pixels per line; 2..4096.

Ports:
- `cp`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  `logic_t`  producer offers `in_pixel`.
- `in_pixel`  in  `pixel24_t`  incoming pixel `{r[23:16], g[15:8], b[7:0]}`.
- `in_ready`  out  `logic_t`  FIFO can accept this cycle.
- `out_valid`  out  `logic_t`  `out_pixel` holds a buffered pixel.
- `out_pixel`  out  `pixel24_t`  head-of-FIFO pixel.
- `out_ready`  in  `logic_t`  consumer takes the head this cycle.
- `out_eol`  out  `logic_t`  head pixel is the last of its line.
- `line_sum`  out  32  sum of r+g+b over the last completed line.
- `line_done`  out  `logic_t`  one-cycle pulse: `line_sum` updated.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Circular FIFO: write and read pointers of `$clog2(DEPTH)` bits, plus a count of `$clog2(DEPTH)+1` bits.
- `in_ready = (count != DEPTH)`. It derives only from registered state and never depends on `out_ready`.
- `out_valid = (count != 0)`. `out_pixel` equals the entry at the read pointer.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - When full, a push cannot occur, so only the pop happens.
  - When empty, a pop cannot occur, so only the push happens. There is no combinational bypass.
- Pointers wrap from DEPTH-1 to 0.
- Column counter `col` (0..LINE_LEN-1) advances on each pop.
  - It wraps to 0 on the pop where `col == LINE_LEN-1`.
  - `out_eol = out_valid && (col == LINE_LEN-1)`.
- Accumulator `acc` is 32 bits. On each pop it adds the zero-extended `r+g+b` of the head pixel.
  - On an eol pop: `line_sum <= acc + rgb(head)`, `acc <= 0`, and `line_done` goes high for the next cycle.
  - Otherwise `line_done <= 0`.
  - Arithmetic wraps modulo 2^32.
- The producer may drop `in_valid` at any time. Dropping `out_ready` with `out_valid` high holds the head and the eol state stable.

## Timing
- Reset values:
  - Pointers, count, `col` and `acc` = 0.
  - `in_ready` = 1.
  - `out_valid`, `out_eol` and `line_done` = 0.
  - `line_sum` = 0.
  - `out_pixel` = don't-care while `out_valid` = 0.
- FIFO storage is not reset.
- Latency: a pixel pushed at edge N is visible on `out_pixel`/`out_valid` after edge N, i.e. in cycle N+1 at the earliest.
- Sustained throughput is one pixel per cycle when `out_ready` is held high.
- `line_done` rises one cycle after the eol pop edge and lasts exactly one cycle. `line_sum` changes on that same edge.
- Reset asserted mid-line discards FIFO contents, the partial `col` and `acc`. Reset asserted mid-stream clears any pending `line_done`. Outputs take their reset values immediately, asynchronously.

## Structure
- The shared typedef include carries `pixel24_t` (24-bit packed `{r,g,b}`) and `logic_t`. This block adds no new types.
- The `rgb` channel-sum function belongs in the same shared include so that other blocks can reuse it.
- Natural sub-module: `v2k_typedef_yee_pixel_fifo`, a generic DEPTH-entry `pixel24_t` FIFO with push/pop, full/empty and count. The top level holds `col`, `acc`, `line_sum` and `line_done`.

## Test plan
- Reset, then idle → `in_ready` = 1, `out_valid` = 0, `line_sum` = 0, `line_done` = 0.
- Push `24'h010203` with `out_ready` = 0 → `out_valid` = 1 next cycle, `out_pixel` = `24'h010203`, count holds at 1.
- `out_ready` = 0, push 4 pixels (DEPTH = 4) → `in_ready` = 0 after the 4th. A 5th `in_valid` is not accepted. Pop once → `in_ready` = 1, and the pops return the 4 pixels in order.
- Continuous push and pop of 8 pixels `24'h010101`, `out_ready` = 1:
  - `out_eol` high with the 8th pixel only.
  - `line_done` pulses one cycle later with `line_sum` = 24.
  - `col` and `acc` restart for the next line.
- 8 pixels of `24'hFFFFFF` → `line_sum` = 8×765 = 6120.
- Simultaneous push and pop at count = 2 → count stays 2 and order is preserved.
- Assert `reset` after 3 pixels of a line → all outputs return to their reset values. The next 8 pops form a fresh line with eol on the 8th.

Source files
------------

// File: rtl/v2k_typedef_yee_pixel_rx_pkg.sv
// Shared pixel types and helpers for the pixel receive path.
// Other pixel-stream blocks reuse these definitions.
package v2k_typedef_yee_pixel_rx_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned PIX_W = 3 * CH_W;
  localparam int unsigned RGB_W = CH_W + 2;
  localparam int unsigned SUM_W = 32;

  typedef logic logic_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel24_t;

  // Channel sum; wide enough for 3 x 255 without overflow.
  function automatic logic [RGB_W-1:0] rgb(input pixel24_t p);
    return RGB_W'(p.r) + RGB_W'(p.g) + RGB_W'(p.b);
  endfunction

endpackage

// File: rtl/v2k_typedef_yee_pixel_fifo.sv
// Generic circular FIFO of pixel24_t entries with push/pop, full/empty and an occupancy count.
// Storage is intentionally not reset; only pointers and count are.
module v2k_typedef_yee_pixel_fifo
  import v2k_typedef_yee_pixel_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  pixel24_t din,
  input  logic     pop,
  output pixel24_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  pixel24_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/v2k_typedef_yee_pixel_rx.sv
// Pixel stream receive endpoint: buffers pixels, marks end-of-line on the head
// pixel and reports the wrapping per-line sum of all colour channels.
module v2k_typedef_yee_pixel_rx
  import v2k_typedef_yee_pixel_rx_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINE_LEN = 8
) (
  input  logic             cp,
  input  logic             reset,
  input  logic_t           in_valid,
  input  pixel24_t         in_pixel,
  output logic_t           in_ready,
  output logic_t           out_valid,
  output pixel24_t         out_pixel,
  input  logic_t           out_ready,
  output logic_t           out_eol,
  output logic [SUM_W-1:0] line_sum,
  output logic_t           line_done
);

  localparam int unsigned COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             eol_hit;
  logic [SUM_W-1:0] head_sum;

  logic [COL_W-1:0] col_q, col_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] line_sum_q, line_sum_d;
  logic             line_done_q, line_done_d;

  v2k_typedef_yee_pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (cp),
    .rst   (reset),
    .push  (push),
    .din   (in_pixel),
    .pop   (pop),
    .dout  (out_pixel),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign eol_hit   = (col_q == COL_LAST);
  assign out_eol   = out_valid && eol_hit;
  assign head_sum  = SUM_W'(rgb(out_pixel));
  assign line_sum  = line_sum_q;
  assign line_done = line_done_q;

  // Line bookkeeping advances only on pops; the eol pop publishes the total.
  always_comb begin
    col_d       = col_q;
    acc_d       = acc_q;
    line_sum_d  = line_sum_q;
    line_done_d = 1'b0;
    if (pop) begin
      if (eol_hit) begin
        col_d       = '0;
        acc_d       = '0;
        line_sum_d  = acc_q + head_sum;
        line_done_d = 1'b1;
      end else begin
        col_d = col_q + COL_W'(1);
        acc_d = acc_q + head_sum;
      end
    end
  end

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      acc_q       <= '0;
      line_sum_q  <= '0;
      line_done_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      acc_q       <= acc_d;
      line_sum_q  <= line_sum_d;
      line_done_q <= line_done_d;
    end
  end

endmodule

// File: tb/tb_v2k_typedef_yee_pixel_rx.sv
// Bench for v2k_typedef_yee_pixel_rx: directed steps plus random traffic,
// checked against a queue-based model of the pixel stream and line sums.
module tb_v2k_typedef_yee_pixel_rx;
  import v2k_typedef_yee_pixel_rx_pkg::*;

  localparam int DEPTH    = 4;
  localparam int LINE_LEN = 8;

  logic        cp;
  logic        reset;
  logic_t      in_valid;
  pixel24_t    in_pixel;
  logic_t      in_ready;
  logic_t      out_valid;
  pixel24_t    out_pixel;
  logic_t      out_ready;
  logic_t      out_eol;
  logic [31:0] line_sum;
  logic_t      line_done;

  int n_checks;
  int n_pass;

  pixel24_t    mq[$];
  int          m_pos;
  logic [31:0] m_acc;
  logic [31:0] m_sum;
  bit          m_done;

  v2k_typedef_yee_pixel_rx #(
    .DEPTH    (DEPTH),
    .LINE_LEN (LINE_LEN)
  ) dut (
    .cp        (cp),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_ready (out_ready),
    .out_eol   (out_eol),
    .line_sum  (line_sum),
    .line_done (line_done)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_pos  = 0;
    m_acc  = 32'd0;
    m_sum  = 32'd0;
    m_done = 1'b0;
  endtask

  task automatic check_outputs();
    chk("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_pixel", 32'(out_pixel), 32'(mq[0]));
    chk("out_eol",   32'(out_eol),   32'(mq.size() != 0 && m_pos == LINE_LEN - 1));
    chk("line_sum",  line_sum,       m_sum);
    chk("line_done", 32'(line_done), 32'(m_done));
  endtask

  // One clock: drive inputs, check against model, advance model, step past edge.
  task automatic cycle(input bit v, input logic [23:0] pix, input bit rdy);
    pixel24_t h;
    bit       do_push;
    bit       do_pop;
    in_valid  = v;
    in_pixel  = pixel24_t'(pix);
    out_ready = rdy;
    #1;
    check_outputs();
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    m_done  = 1'b0;
    if (do_pop) begin
      h = mq.pop_front();
      m_acc = m_acc + 32'(h.r) + 32'(h.g) + 32'(h.b);
      m_pos++;
      if (m_pos == LINE_LEN) begin
        m_sum  = m_acc;
        m_acc  = 32'd0;
        m_pos  = 0;
        m_done = 1'b1;
      end
    end
    if (do_push) mq.push_back(pixel24_t'(pix));
    @(posedge cp);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_eol",   32'(out_eol),   32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_line_sum",  line_sum,       32'd0);
    @(posedge cp);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge cp);
    #1;
    reset = 1'b0;

    // Idle after reset
    chk("idle_in_ready",  32'(in_ready),  32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_line_sum",  line_sum,       32'd0);
    chk("idle_line_done", 32'(line_done), 32'd0);
    repeat (2) cycle(1'b0, 24'h0, 1'b0);

    // Single push, held with out_ready low
    cycle(1'b1, 24'h010203, 1'b0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pixel", 32'(out_pixel), 32'h010203);
    cycle(1'b0, 24'h0, 1'b0);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_pixel", 32'(out_pixel), 32'h010203);

    // Fill to full, reject a fifth, pop once, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 24'($urandom), 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 24'hABCDEF, 1'b0);
    chk("full_reject", 32'(in_ready), 32'd0);
    cycle(1'b0, 24'h0, 1'b1);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 24'h0, 1'b1);
    chk("drained", 32'(out_valid), 32'd0);
    cycle(1'b0, 24'h0, 1'b0);

    // Continuous line of 24'h010101
    do_reset();
    for (int i = 0; i < LINE_LEN; i++) cycle(1'b1, 24'h010101, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
    chk("line1_done", 32'(line_done), 32'd1);
    chk("line1_sum",  line_sum,       32'd24);
    cycle(1'b0, 24'h0, 1'b0);
    chk("line1_pulse_end", 32'(line_done), 32'd0);

    // Line of white pixels
    for (int i = 0; i < LINE_LEN; i++) cycle(1'b1, 24'hFFFFFF, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
    chk("line2_done", 32'(line_done), 32'd1);
    chk("line2_sum",  line_sum,       32'd6120);

    // Reset while line_done is pending clears it
    do_reset();

    // Simultaneous push and pop at count 2
    cycle(1'b1, 24'h112233, 1'b0);
    cycle(1'b1, 24'h445566, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'($urandom), 1'b1);
    chk("cnt2_valid", 32'(out_valid), 32'd1);
    chk("cnt2_ready", 32'(in_ready),  32'd1);
    repeat (3) cycle(1'b0, 24'h0, 1'b1);

    // Reset mid-line, then a fresh full line
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < LINE_LEN; i++) cycle(1'b1, 24'($urandom), 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
    chk("fresh_line_done", 32'(line_done), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 24'($urandom), ($urandom_range(0, 3) != 0));
    repeat (DEPTH + 1) cycle(1'b0, 24'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
